param_reg_file_sb: RTL
======================

Name: param_reg_file_sb

Overview:
- Next-generation general-purpose register file for the pipelined core.
- Parametrised in data width and register count; two combinational read ports, one write port, same-cycle write-to-read bypass, configurable hard-wired zero register, and a parametrised debug tap register.
- Integrates a pending-write scoreboard. Decode marks a destination busy at issue; writeback clears it. Hazard unit consumes the busy flags to stall.
- Sits between decode (read/issue) and writeback (write).

Parameters:
- DATA_W, 16, register width in bits
- NREGS, 8, number of registers; power of two, >=2
- ADDR_W, $clog2(NREGS), register index width (derived; not overridden)
- ZERO_REG, 1, 1 = register 0 reads 0 and ignores writes and issues; 0 = register 0 is ordinary
- TAP_IDX, NREGS-1, index exported on tap_data

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- ra  in  ADDR_W  read port A index
- rb  in  ADDR_W  read port B index
- bus_a  out  DATA_W  read data A (combinational)
- bus_b  out  DATA_W  read data B (combinational)
- busy_a  out  1  register ra has a pending write
- busy_b  out  1  register rb has a pending write
- we  in  1  write enable (writeback)
- rw  in  ADDR_W  write index
- bus_w  in  DATA_W  write data
- issue_valid  in  1  decode issues an instruction with destination
- issue_rd  in  ADDR_W  destination of the issued instruction
- tap_data  out  DATA_W  contents of register TAP_IDX (registered array value, no bypass)
- busy_vec  out  NREGS  full scoreboard, bit i = register i pending

Behaviour:
- Storage: NREGS x DATA_W register array plus NREGS-bit busy vector, all flops.
- Reset (rst=1 at rising edge): every register <= 0; busy_vec <= 0. After reset, bus_a, bus_b and tap_data read 0, and busy_a, busy_b and busy_vec are 0. Reset overrides we and issue_valid in the same cycle. Reset mid-sequence discards all pending writes.
- Write: we=1 and not (ZERO_REG and rw==0) -> reg[rw] <= bus_w at the rising edge.
- Read (combinational, 0-cycle latency):
  - bus_a = 0 if ZERO_REG and ra==0.
  - Else bus_a = bus_w if we and rw==ra (bypass).
  - Else bus_a = reg[ra].
  - bus_b identical using rb.
- Bypass applies to both ports simultaneously when ra==rb==rw.
- Scoreboard, per rising edge for register i:
  - set if issue_valid and issue_rd==i;
  - clear if we and rw==i;
  - set and clear on the same i in the same cycle -> set wins (a newer producer is outstanding).
  - With ZERO_REG=1, index 0 is never set; busy_vec[0] is constant 0.
- busy_a = busy_vec[ra] and not (we and rw==ra). Same for busy_b with rb. The bypassed value satisfies the consumer, so no stall.
- Write to a non-busy register is legal: data is written and the busy bit stays 0.
- Multiple issues to the same register before writeback: single bit, stays set until the next write to that index. In-order writeback makes this correct.
- Out-of-range indices cannot occur (NREGS is a power of two).
- No X on outputs after the first reset.

Decomposition:
- Shared package regfile_pkg: default DATA_W/NREGS constants, REG_ZERO index constant, reset-value constant.
- One sub-module rf_scoreboard: busy vector with set/clear priority and per-port busy lookup. Array, bypass and tap stay in the top.

Test Plan (DATA_W=16, NREGS=8, ZERO_REG=1, TAP_IDX=7):
1. Assert rst 2 cycles after random writes -> all reads 0, busy_vec=8'h00, tap_data=16'h0000.
2. we=1 rw=3 bus_w=16'hBEEF with ra=3 in the same cycle -> bus_a=16'hBEEF immediately (bypass); next cycle with we=0 -> bus_a=16'hBEEF from the array.
3. we=1 rw=0 bus_w=16'h1234, then ra=0 -> bus_a=16'h0000. Issue to rd=0 -> busy_vec[0] stays 0.
4. issue_valid rd=5 -> next cycle busy_vec=8'h20 and busy_a=1 for ra=5. Then we rw=5 bus_w=16'h0042 -> busy_a=0 in that cycle, bus_a=16'h0042, and busy_vec=8'h00 next cycle.
5. Same cycle: issue_valid rd=6 and we rw=6 bus_w=16'h0007 -> reg6=16'h0007 and busy_vec[6]=1 afterward (set wins).
6. we rw=7 bus_w=16'hA5A5 -> tap_data is unchanged in the write cycle and reads 16'hA5A5 the following cycle. Assert rst while busy_vec=8'hFE -> busy_vec=8'h00 next cycle.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared constants for the general-purpose register file.
// Default geometry, the hard-wired zero index and the reset fill value.
package regfile_pkg;

    localparam int DEF_DATA_W = 16;
    localparam int DEF_NREGS  = 8;

    // Index of the register that may be hard-wired to zero.
    localparam int REG_ZERO = 0;

    // Every storage bit takes this value on reset.
    localparam logic RST_BIT = 1'b0;

endpackage

// File: rtl/rf_scoreboard.sv
// Pending-write scoreboard: one busy bit per register, set by issue,
// cleared by writeback, with per-port busy lookup for the hazard unit.
//   clk, rst           : clock, synchronous active-high reset
//   issue_valid/rd     : decode marks a destination busy
//   we/rw              : writeback clears the written index
//   ra/rb -> busy_a/b  : per-port pending flags (bypass-aware)
//   busy_vec           : full scoreboard
module rf_scoreboard
    import regfile_pkg::*;
#(
    parameter int NREGS    = DEF_NREGS,
    parameter int ADDR_W   = $clog2(NREGS),
    parameter int ZERO_REG = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              issue_valid,
    input  logic [ADDR_W-1:0] issue_rd,
    input  logic              we,
    input  logic [ADDR_W-1:0] rw,
    input  logic [ADDR_W-1:0] ra,
    input  logic [ADDR_W-1:0] rb,
    output logic              busy_a,
    output logic              busy_b,
    output logic [NREGS-1:0]  busy_vec
);

    logic [NREGS-1:0] set_vec;
    logic [NREGS-1:0] clr_vec;
    logic [NREGS-1:0] busy_nxt;

    always_comb begin
        set_vec = '0;
        clr_vec = '0;
        if (issue_valid)
            set_vec[issue_rd] = 1'b1;
        if (we)
            clr_vec[rw] = 1'b1;
        // Set wins: a newer producer is still outstanding.
        busy_nxt = (busy_vec & ~clr_vec) | set_vec;
        if (ZERO_REG != 0)
            busy_nxt[REG_ZERO] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst)
            busy_vec <= {NREGS{RST_BIT}};
        else
            busy_vec <= busy_nxt;
    end

    // A value arriving this cycle is bypassed, so it does not stall.
    assign busy_a = busy_vec[ra] & ~(we && (rw == ra));
    assign busy_b = busy_vec[rb] & ~(we && (rw == rb));

endmodule

// File: rtl/param_reg_file_sb.sv
// Parametrised register file: 2 combinational read ports with write
// bypass, 1 write port, optional zero register, debug tap, scoreboard.
//   clk, rst               : clock, synchronous active-high reset
//   ra/rb -> bus_a/bus_b   : read indices and data
//   busy_a/busy_b          : pending-write flags for ra/rb
//   we/rw/bus_w            : writeback port
//   issue_valid/issue_rd   : decode issue of a destination
//   tap_data               : array value of register TAP_IDX
//   busy_vec               : full scoreboard
module param_reg_file_sb
    import regfile_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int NREGS    = DEF_NREGS,
    parameter int ZERO_REG = 1,
    parameter int TAP_IDX  = NREGS - 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [$clog2(NREGS)-1:0] ra,
    input  logic [$clog2(NREGS)-1:0] rb,
    output logic [DATA_W-1:0]        bus_a,
    output logic [DATA_W-1:0]        bus_b,
    output logic                     busy_a,
    output logic                     busy_b,
    input  logic                     we,
    input  logic [$clog2(NREGS)-1:0] rw,
    input  logic [DATA_W-1:0]        bus_w,
    input  logic                     issue_valid,
    input  logic [$clog2(NREGS)-1:0] issue_rd,
    output logic [DATA_W-1:0]        tap_data,
    output logic [NREGS-1:0]         busy_vec
);

    localparam int ADDR_W = $clog2(NREGS);
    localparam logic [ADDR_W-1:0] ZIDX = ADDR_W'(REG_ZERO);

    logic [DATA_W-1:0] regs [NREGS];
    logic              wr_ok;
    logic              zero_a;
    logic              zero_b;

    assign wr_ok  = we && !((ZERO_REG != 0) && (rw == ZIDX));
    assign zero_a = (ZERO_REG != 0) && (ra == ZIDX);
    assign zero_b = (ZERO_REG != 0) && (rb == ZIDX);

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++)
                regs[i] <= {DATA_W{RST_BIT}};
        end else if (wr_ok) begin
            regs[rw] <= bus_w;
        end
    end

    always_comb begin
        bus_a = regs[ra];
        if (zero_a)
            bus_a = '0;
        else if (we && (rw == ra))
            bus_a = bus_w;
    end

    always_comb begin
        bus_b = regs[rb];
        if (zero_b)
            bus_b = '0;
        else if (we && (rw == rb))
            bus_b = bus_w;
    end

    // Tap shows the stored value only; no bypass.
    assign tap_data = regs[TAP_IDX];

    rf_scoreboard #(
        .NREGS    (NREGS),
        .ADDR_W   (ADDR_W),
        .ZERO_REG (ZERO_REG)
    ) u_sb (
        .clk         (clk),
        .rst         (rst),
        .issue_valid (issue_valid),
        .issue_rd    (issue_rd),
        .we          (we),
        .rw          (rw),
        .ra          (ra),
        .rb          (rb),
        .busy_a      (busy_a),
        .busy_b      (busy_b),
        .busy_vec    (busy_vec)
    );

endmodule
